icache_fetch_responder: RTL

//  Responder side of the instruction-fetch interface driven by the program counter.

---
 rtl/icache_fetch_responder_if.sv | 22 ++
 rtl/icache_fetch_responder.sv | 115 +++++++++++
 2 files changed

// File: rtl/icache_fetch_responder_if.sv
// Fetch-side and RAM-side handshake bundle for the instruction cache responder.
// The slave view belongs to the cache; the master view belongs to whatever drives it.
interface icache_fetch_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_fetch_responder.sv
// Direct-mapped, one-word-block instruction cache with zero-latency hits,
// a two-state RAM fill FSM and saturating hit/miss counters.
//
// state | meaning
// IDLE  | answer hits from the arrays; a miss latches miss_addr and starts a fill
// FILL  | RAM read of miss_addr in progress; frame written when iwait drops
module icache_fetch_responder #(
    parameter int NFRAMES = 16,
    parameter int CNT_W   = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        inval,
    icache_fetch_responder_if.slave     bus,
    output logic [CNT_W-1:0]            hit_count,
    output logic [CNT_W-1:0]            miss_count
);
    localparam int IDX_W = $clog2(NFRAMES);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [NFRAMES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]   tag_q  [NFRAMES];
    logic [31:0]        data_q [NFRAMES];

    logic [IDX_W-1:0]   req_idx, miss_idx;
    logic [TAG_W-1:0]   req_tag, miss_tag;
    logic               hit;
    logic               fill_we;
    logic               unused_addr_bits;

    assign req_idx  = bus.imemaddr[IDX_W+1:2];
    assign req_tag  = bus.imemaddr[31:IDX_W+2];
    assign miss_idx = miss_addr_q[IDX_W+1:2];
    assign miss_tag = miss_addr_q[31:IDX_W+2];
    assign unused_addr_bits = ^{bus.imemaddr[1:0], miss_addr_q[1:0]};

    // inval masks the hit so neither the datapath nor the hit counter sees it
    assign hit = nRST && (state_q == IDLE) && bus.imemREN && !inval &&
                 valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign fill_we = (state_q == FILL) && !bus.iwait && !inval;

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? data_q[req_idx] : 32'h0;
    assign bus.iREN     = (state_q == FILL);
    assign bus.iaddr    = (state_q == FILL) ? miss_addr_q : 32'h0;

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (hit_cnt_q != {CNT_W{1'b1}})
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end else if (bus.imemREN && !inval) begin
                    state_d     = FILL;
                    miss_addr_d = {bus.imemaddr[31:2], 2'b00};
                    if (miss_cnt_q != {CNT_W{1'b1}})
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                end
            end
            FILL: begin
                if (fill_we) begin
                    state_d           = IDLE;
                    valid_d[miss_idx] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (inval) begin
            state_d = IDLE;
            valid_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'h0;
            valid_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // tag/data carry no reset; valid_q alone qualifies them
    always_ff @(posedge CLK) begin
        if (nRST && fill_we) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= bus.iload;
        end
    end
endmodule
